// File: rtl/ir_pkg.sv
// Shared constants and types for the infrared line-tracking monitor.
package ir_pkg;

  localparam int CH_L = 2;
  localparam int CH_C = 1;
  localparam int CH_R = 0;

  localparam logic [1:0] DIR_STRAIGHT = 2'd0;
  localparam logic [1:0] DIR_LEFT     = 2'd1;
  localparam logic [1:0] DIR_RIGHT    = 2'd2;
  localparam logic [1:0] DIR_CROSS    = 2'd3;

  typedef enum logic {
    TRACK = 1'b0,
    LOST  = 1'b1
  } trk_state_e;

  // Ambiguous patterns (101, 000) keep the previous heading.
  function automatic logic [1:0] dir_decode(input logic [2:0] lvl, input logic [1:0] prev);
    logic [2:0] w_lcr;
    w_lcr = {lvl[CH_L], lvl[CH_C], lvl[CH_R]};
    case (w_lcr)
      3'b010:         return DIR_STRAIGHT;
      3'b110, 3'b100: return DIR_LEFT;
      3'b011, 3'b001: return DIR_RIGHT;
      3'b111:         return DIR_CROSS;
      default:        return prev;
    endcase
  endfunction

endpackage

// File: rtl/ir_debounce.sv
// One sensor channel: 2-flop synchroniser followed by a consecutive-mismatch debouncer.
module ir_debounce #(
  parameter int DEB_CYCLES = 100000,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  input  logic din,
  output logic level,
  output logic toggle
);

  localparam int             CW      = $clog2(DEB_CYCLES);
  localparam logic [CW-1:0]  CNT_MAX = CW'(DEB_CYCLES - 1);

  logic          r_s1, r_s2, r_level;
  logic [CW-1:0] r_cnt;
  logic          w_mis, w_hit;

  assign w_mis  = (r_s2 != r_level);
  assign w_hit  = en && w_mis && (r_cnt == CNT_MAX);
  assign level  = r_level;
  assign toggle = w_hit;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_level <= 1'b0;
      r_cnt   <= '0;
    end else begin
      r_s1 <= din ^ ACTIVE_LOW;
      r_s2 <= r_s1;
      // Any agreeing cycle, or disable, throws away the partial count.
      if (!en || !w_mis || w_hit) r_cnt <= '0;
      else                        r_cnt <= r_cnt + 1'b1;
      if (w_hit) r_level <= ~r_level;
    end
  end

endmodule

// File: rtl/ir_track_monitor.sv
// Debounced 3-channel IR line tracker: direction decode, line-loss timeout and sticky change events.
module ir_track_monitor
  import ir_pkg::*;
#(
  parameter int DEB_CYCLES  = 100000,
  parameter int LOST_CYCLES = 5000000,
  parameter bit ACTIVE_LOW  = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] sens_in,
  input  logic       enable,
  input  logic       clr,
  input  logic [2:0] clr_mask,
  output logic [2:0] state_out,
  output logic [2:0] event_pending,
  output logic       irq,
  output logic [1:0] dir,
  output logic       lost
);

  localparam int            LW   = $clog2(LOST_CYCLES);
  localparam logic [LW-1:0] LMAX = LW'(LOST_CYCLES - 1);

  logic [2:0]    w_level, w_tog;
  logic [2:0]    r_evt;
  logic [1:0]    r_dir;
  trk_state_e    r_state, w_state_nxt;
  logic [LW-1:0] r_lcnt, w_lcnt_nxt;
  logic          r_lost;

  genvar g;
  for (g = 0; g < 3; g++) begin : g_ch
    ir_debounce #(
      .DEB_CYCLES(DEB_CYCLES),
      .ACTIVE_LOW(ACTIVE_LOW)
    ) u_deb (
      .clk   (clk),
      .rst   (rst),
      .en    (enable),
      .din   (sens_in[g]),
      .level (w_level[g]),
      .toggle(w_tog[g])
    );
  end

  assign state_out     = w_level;
  assign event_pending = r_evt;
  assign irq           = |r_evt;
  assign dir           = r_dir;
  assign lost          = r_lost;

  // Set is OR-ed in after the clear so a same-cycle toggle survives.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_evt <= '0;
      r_dir <= DIR_STRAIGHT;
    end else begin
      r_evt <= (r_evt & ~(clr ? clr_mask : 3'b000)) | w_tog;
      r_dir <= dir_decode(w_level, r_dir);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= TRACK;
      r_lcnt  <= '0;
      r_lost  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_lcnt  <= w_lcnt_nxt;
      r_lost  <= (w_state_nxt == LOST);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_lcnt_nxt  = r_lcnt;
    if (!enable) begin
      w_lcnt_nxt = '0;
    end else begin
      case (r_state)
        TRACK: begin
          if (w_level == 3'b000) begin
            if (r_lcnt == LMAX) w_state_nxt = LOST;
            else                w_lcnt_nxt  = r_lcnt + 1'b1;
          end else begin
            w_lcnt_nxt = '0;
          end
        end
        LOST: begin
          if (w_level != 3'b000) begin
            w_state_nxt = TRACK;
            w_lcnt_nxt  = '0;
          end
        end
        default: w_state_nxt = TRACK;
      endcase
    end
  end

endmodule

// File: tb/tb_ir_track_monitor.sv
// Directed scenarios plus randomized traffic against a behavioural model of the monitor.
module tb_ir_track_monitor;

  localparam int DEB   = 4;
  localparam int LOSTC = 10;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       enable = 1'b1;
  logic       clr = 1'b0;
  logic [2:0] sens_in = 3'b000;
  logic [2:0] clr_mask = 3'b000;
  logic [2:0] state_out, event_pending;
  logic       irq, lost;
  logic [1:0] dir;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  ir_track_monitor #(.DEB_CYCLES(DEB), .LOST_CYCLES(LOSTC), .ACTIVE_LOW(1'b0)) dut (
    .clk          (clk),
    .rst          (rst),
    .sens_in      (sens_in),
    .enable       (enable),
    .clr          (clr),
    .clr_mask     (clr_mask),
    .state_out    (state_out),
    .event_pending(event_pending),
    .irq          (irq),
    .dir          (dir),
    .lost         (lost)
  );

  // Behavioural model: sensor seen two samples late, a level is accepted after
  // DEB consecutive disagreeing samples, lost after LOSTC consecutive all-off samples.
  logic [2:0] m_s1 = '0, m_s2 = '0, m_state = '0, m_evt = '0;
  int         m_run [3] = '{0, 0, 0};
  logic [1:0] m_dir = '0;
  int         m_zrun = 0;
  logic       m_lost = 1'b0;

  function automatic void model_step();
    logic [2:0] old;
    logic [2:0] tog;
    old = m_state;
    tog = '0;
    if (rst) begin
      m_s1 = '0; m_s2 = '0; m_state = '0; m_evt = '0;
      m_run = '{0, 0, 0}; m_dir = 2'd0; m_zrun = 0; m_lost = 1'b0;
      return;
    end
    for (int i = 0; i < 3; i++) begin
      if (enable && (m_s2[i] != m_state[i])) begin
        m_run[i] = m_run[i] + 1;
        if (m_run[i] == DEB) begin
          tog[i] = 1'b1;
          m_run[i] = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_state = m_state ^ tog;
    m_evt = (m_evt & ~(clr ? clr_mask : 3'b000)) | tog;
    case (old)
      3'b010:         m_dir = 2'd0;
      3'b110, 3'b100: m_dir = 2'd1;
      3'b011, 3'b001: m_dir = 2'd2;
      3'b111:         m_dir = 2'd3;
      default:        ;
    endcase
    if (!enable) m_zrun = 0;
    else if (old != 3'b000) begin
      m_zrun = 0;
      m_lost = 1'b0;
    end else if (!m_lost) begin
      m_zrun = m_zrun + 1;
      if (m_zrun == LOSTC) m_lost = 1'b1;
    end
    m_s2 = m_s1;
    m_s1 = sens_in;
  endfunction

  function automatic logic [9:0] m_vec();
    return {m_state, m_evt, |m_evt, m_dir, m_lost};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic test_reset();
    int n;
    rst = 1'b1; sens_in = 3'b111;
    repeat (3) tick();
    checks++;
    if ({state_out, event_pending, irq, dir, lost} !== 10'd0) begin
      errors++;
      $display("FAIL reset_state: got %b want %b", {state_out, event_pending, irq, dir, lost}, 10'd0);
    end
    rst = 1'b0;
    for (n = 1; n <= 20; n++) begin
      tick();
      if (state_out == 3'b111) break;
    end
    checks++;
    if (n != DEB + 2) begin
      errors++;
      $display("FAIL reset_latency: got %0d cycles want %0d", n, DEB + 2);
    end
  endtask

  task automatic test_glitch();
    int n;
    sens_in = 3'b000;
    repeat (8) tick();
    clr = 1'b1; clr_mask = 3'b111;
    tick();
    clr = 1'b0; clr_mask = 3'b000;
    sens_in = 3'b010;
    repeat (DEB - 1) tick();
    sens_in = 3'b000;
    repeat (8) tick();
    checks++;
    if ({state_out, event_pending} !== 6'b000_000) begin
      errors++;
      $display("FAIL glitch_reject: got %b want %b", {state_out, event_pending}, 6'b0);
    end
    sens_in = 3'b010;
    for (n = 1; n <= 20; n++) begin
      tick();
      if (state_out == 3'b010) break;
    end
    checks++;
    if (n != DEB + 2 || event_pending !== 3'b010 || irq !== 1'b1) begin
      errors++;
      $display("FAIL glitch_accept: got n=%0d evt=%b irq=%b want n=%0d evt=010 irq=1",
               n, event_pending, irq, DEB + 2);
    end
    tick();
    checks++;
    if (dir !== 2'd0) begin
      errors++;
      $display("FAIL glitch_dir: got %0d want 0", dir);
    end
  endtask

  task automatic test_decode();
    logic [2:0] pats [4] = '{3'b110, 3'b011, 3'b111, 3'b101};
    logic [1:0] exps [4] = '{2'd1, 2'd2, 2'd3, 2'd3};
    for (int k = 0; k < 4; k++) begin
      sens_in = pats[k];
      repeat (DEB + 4) tick();
      checks++;
      if (state_out !== pats[k] || dir !== exps[k]) begin
        errors++;
        $display("FAIL decode_%0d: got state=%b dir=%0d want state=%b dir=%0d",
                 k, state_out, dir, pats[k], exps[k]);
      end
    end
  endtask

  task automatic test_clear();
    clr = 1'b1; clr_mask = 3'b111;
    tick();
    clr = 1'b0;
    sens_in = 3'b010;
    repeat (DEB + 4) tick();
    clr = 1'b1; clr_mask = 3'b000;
    tick();
    checks++;
    if (event_pending !== 3'b111) begin
      errors++;
      $display("FAIL clr_noop: got %b want 111", event_pending);
    end
    clr_mask = 3'b101;
    tick();
    checks++;
    if (event_pending !== 3'b010 || irq !== 1'b1) begin
      errors++;
      $display("FAIL clr_mask101: got evt=%b irq=%b want 010 1", event_pending, irq);
    end
    clr_mask = 3'b010;
    tick();
    clr = 1'b0; clr_mask = 3'b000;
    checks++;
    if (event_pending !== 3'b000 || irq !== 1'b0) begin
      errors++;
      $display("FAIL clr_all: got evt=%b irq=%b want 000 0", event_pending, irq);
    end
    sens_in = 3'b000;
    repeat (DEB + 1) tick();
    clr = 1'b1; clr_mask = 3'b010;
    tick();
    clr = 1'b0; clr_mask = 3'b000;
    checks++;
    if (state_out !== 3'b000 || event_pending !== 3'b010) begin
      errors++;
      $display("FAIL clr_set_wins: got state=%b evt=%b want 000 010", state_out, event_pending);
    end
  endtask

  task automatic test_lost();
    int n;
    sens_in = 3'b010;
    repeat (DEB + 4) tick();
    sens_in = 3'b000;
    for (n = 1; n <= 20; n++) begin
      tick();
      if (state_out == 3'b000) break;
    end
    for (n = 1; n <= 30; n++) begin
      tick();
      if (lost) break;
    end
    checks++;
    if (n != LOSTC) begin
      errors++;
      $display("FAIL lost_timeout: got %0d cycles want %0d", n, LOSTC);
    end
    sens_in = 3'b001;
    for (n = 1; n <= 20; n++) begin
      tick();
      if (state_out == 3'b001) break;
    end
    checks++;
    if (lost !== 1'b1 || n != DEB + 2) begin
      errors++;
      $display("FAIL lost_hold: got lost=%b n=%0d want 1 %0d", lost, n, DEB + 2);
    end
    tick();
    checks++;
    if (lost !== 1'b0 || dir !== 2'd2) begin
      errors++;
      $display("FAIL lost_exit: got lost=%b dir=%0d want 0 2", lost, dir);
    end
  endtask

  task automatic test_enable_rst();
    int n;
    sens_in = 3'b000;
    repeat (4) tick();
    enable = 1'b0;
    repeat (10) tick();
    checks++;
    if (state_out !== 3'b001) begin
      errors++;
      $display("FAIL en_hold: got %b want 001", state_out);
    end
    clr = 1'b1; clr_mask = 3'b111;
    tick();
    clr = 1'b0; clr_mask = 3'b000;
    checks++;
    if (event_pending !== 3'b000) begin
      errors++;
      $display("FAIL en_clr: got %b want 000", event_pending);
    end
    enable = 1'b1;
    for (n = 1; n <= 20; n++) begin
      tick();
      if (state_out == 3'b000) break;
    end
    checks++;
    if (n != DEB) begin
      errors++;
      $display("FAIL en_restart: got %0d cycles want %0d", n, DEB);
    end
    repeat (5) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (n = 1; n <= 30; n++) begin
      tick();
      if (lost) break;
    end
    checks++;
    if (n != LOSTC) begin
      errors++;
      $display("FAIL rst_lost_restart: got %0d cycles want %0d", n, LOSTC);
    end
    checks++;
    if ({state_out, event_pending, irq, dir, lost} !== m_vec()) begin
      errors++;
      $display("FAIL model_sync: got %b want %b", {state_out, event_pending, irq, dir, lost}, m_vec());
    end
  endtask

  task automatic test_random();
    int hold;
    hold = 0;
    for (int t = 0; t < 1500; t++) begin
      if (hold == 0) begin
        sens_in = 3'($urandom_range(0, 7));
        hold = $urandom_range(1, 8);
      end
      hold--;
      enable   = ($urandom_range(0, 9) != 0);
      clr      = ($urandom_range(0, 3) == 0);
      clr_mask = 3'($urandom_range(0, 7));
      rst      = ($urandom_range(0, 199) == 0);
      tick();
      checks++;
      if ({state_out, event_pending, irq, dir, lost} !== m_vec()) begin
        errors++;
        $display("FAIL random_t%0d: got %b want %b", t,
                 {state_out, event_pending, irq, dir, lost}, m_vec());
      end
    end
    rst = 1'b0; clr = 1'b0; enable = 1'b1;
  endtask

  initial begin
    test_reset();
    test_glitch();
    test_decode();
    test_clear();
    test_lost();
    test_enable_rst();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ir_track_monitor.md
Name: ir_track_monitor

Overview:
- Consumer stage for the three infrared sensor channels, one per `infrarojo` instance: left = ch2, centre = ch1, right = ch0.
- Per channel: synchronises, debounces and edge-detects the filtered sensor bit.
- Decodes the three debounced bits into a line-tracking direction code and flags line loss after a timeout.
- Keeps sticky per-channel change events with an irq line for the SoC CSR/firmware side.

Parameters:
- DEB_CYCLES, 100000: consecutive mismatch cycles required to accept a new level (1 ms at 100 MHz); must be >= 2.
- LOST_CYCLES, 5000000: consecutive all-off debounced cycles before lost is asserted; must be >= 2.
- ACTIVE_LOW, 0: 1 inverts sens_in before synchronisation.

Ports:
- clk, in, 1: system clock, single clock domain.
- rst, in, 1: synchronous, active-high reset.
- sens_in, in, 3: asynchronous sensor bits {left, centre, right}.
- enable, in, 1: 1 = monitoring active.
- clr, in, 1: one-cycle pulse that clears event_pending bits selected by clr_mask.
- clr_mask, in, 3: channel select for clr.
- state_out, out, 3: debounced sensor levels.
- event_pending, out, 3: sticky per-channel change flags.
- irq, out, 1: OR of event_pending.
- dir, out, 2: direction code, 0 STRAIGHT, 1 LEFT, 2 RIGHT, 3 CROSS.
- lost, out, 1: line lost.

Behaviour:
- Reset (rst=1 sampled at a clk edge):
  - all synchroniser flops, counters, state_out, event_pending, irq and lost go to 0;
  - dir goes to STRAIGHT; FSM goes to TRACK.
  - rst mid-debounce or mid-timeout discards the partial count.
- Synchroniser: 2 flops per channel, after optional inversion.
- Debounce, per channel:
  - counter increments each cycle that sync != state_out[i], and resets to 0 on any cycle they are equal.
  - On a mismatch cycle with counter == DEB_CYCLES-1: state_out[i] toggles and the counter returns to 0.
  - Latency: state_out[i] changes exactly DEB_CYCLES+2 cycles after a stable input step.
  - Glitches shorter than DEB_CYCLES are rejected entirely.
- Events:
  - any state_out[i] toggle sets event_pending[i] on the same edge the toggle is registered.
  - clr with clr_mask[i]=1 clears event_pending[i].
  - A set and a clear on the same cycle: set wins.
  - clr with mask 000 is a no-op.
  - irq = |event_pending, combinational from registers, so no added latency.
- enable=0:
  - debounce counters and the lost counter are held at 0;
  - state_out, event_pending, dir and lost hold their values; no new events are generated.
  - clr remains functional.
  - Debouncing restarts from count 0 when enable returns to 1.
- Direction decode, from state_out {l,c,r}, registered (1 cycle after state_out):
  - 010 -> STRAIGHT;
  - 110 or 100 -> LEFT;
  - 011 or 001 -> RIGHT;
  - 111 -> CROSS;
  - 101 and 000 -> hold the previous dir.
- FSM, states TRACK and LOST:
  - TRACK: lost counter increments while state_out == 000 and resets otherwise. At counter == LOST_CYCLES-1 with 000 -> LOST, and lost=1 on the next cycle.
  - LOST: the counter is frozen (no wrap). Any nonzero state_out -> TRACK, with lost=0 and counter=0 on the next cycle.
  - In LOST, dir holds its last valid value.
- Widths: counter widths are $clog2 of the respective parameter; no arithmetic overflow is possible because counters never exceed parameter-1.

Decomposition:
- Package ir_pkg: dir code constants (DIR_STRAIGHT/LEFT/RIGHT/CROSS), FSM state type (TRACK/LOST), channel index constants (CH_L=2, CH_C=1, CH_R=0).
- Sub-module ir_debounce (params DEB_CYCLES, ACTIVE_LOW; ports clk, rst, en, din, level, toggle), instantiated 3x. Event, decode and FSM logic stay in the top.

Test Plan (DEB_CYCLES=4, LOST_CYCLES=10):
- Reset behaviour: rst high 3 cycles, sens_in=111 -> all outputs 0, dir=0. After release, state_out=111 exactly 6 cycles after the first sampled edge.
- Glitch rejection: sens_in=000; pulse bit1 high for 3 cycles -> state_out stays 000, event_pending=000. Hold it for 4+ cycles -> state_out=010 at cycle 6, event_pending=010, irq=1, and dir=STRAIGHT one cycle later.
- Decode and hold: step state_out through 110, 011, 111, 101 -> dir=1, 2, 3, then stays 3.
- Clear priority: event_pending=111; clr=1 with mask 101 -> 010. clr on bit1 in the same cycle as a new bit1 toggle -> bit1 remains 1.
- Lost timeout: state_out to 000 -> lost=1 after exactly 10 cycles of 000 plus 1. Then sens_in=001 -> lost=0 one cycle after state_out=001, dir=RIGHT.
- Enable and reset mid-operation: deassert enable mid-debounce at count 2 -> no change. Re-enable -> the full 4-cycle debounce is required. rst mid lost-count -> the counter restarts from 0.
